// File: rtl/playseq_pkg.sv
// Shared constants for the playseq button front end: FSM state codes, debounce default and a
// one-hot helper.
package playseq_pkg;

  localparam int unsigned DebounceCyclesDefault = 20;

  localparam logic [1:0] StOcioso      = 2'b00;
  localparam logic [1:0] StFiltraAtivo = 2'b01;
  localparam logic [1:0] StPressionado = 2'b10;
  localparam logic [1:0] StFiltraSolta = 2'b11;

  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer bringing the asynchronous raw button levels into the clock domain.
module sincronizador_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/playseq_entrada_botoes.sv
// Debounces four push buttons into a one-hot code with press/release pulses; multi-button presses
// are flagged and never produce a move.
module playseq_entrada_botoes
  import playseq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_brutos,
  output logic [3:0] botoes,
  output logic       tem_jogada,
  output logic       soltou,
  output logic       multipla,
  output logic [1:0] db_estado
);

  localparam logic [7:0] CntFim = 8'(DEBOUNCE_CYCLES - 1);

  logic [3:0] s_sync;
  logic [1:0] estado_q, estado_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0] cand_q, cand_d;
  logic [3:0] botoes_q, botoes_d;
  logic       tem_q, tem_d;
  logic       soltou_q, soltou_d;
  logic       mult_q, mult_d;

  sincronizador_2ff #(
    .WIDTH (4)
  ) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes_brutos),
    .q     (s_sync)
  );

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    botoes_d = botoes_q;
    mult_d   = mult_q;
    tem_d    = 1'b0;
    soltou_d = 1'b0;
    unique case (estado_q)
      StOcioso: begin
        if (s_sync != 4'b0000) begin
          cand_d   = s_sync;
          cnt_d    = 8'd0;
          estado_d = StFiltraAtivo;
        end
      end
      StFiltraAtivo: begin
        if (s_sync == 4'b0000) begin
          estado_d = StOcioso;
        end else if (s_sync != cand_q) begin
          cand_d = s_sync;
          cnt_d  = 8'd0;
        end else if (cnt_q == CntFim) begin
          estado_d = StPressionado;
          if (eh_one_hot(cand_q)) begin
            botoes_d = cand_q;
            tem_d    = 1'b1;
          end else begin
            botoes_d = 4'b0000;
            mult_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPressionado: begin
        if (s_sync != cand_q) begin
          cnt_d    = 8'd0;
          estado_d = StFiltraSolta;
        end
      end
      StFiltraSolta: begin
        if (s_sync == cand_q) begin
          estado_d = StPressionado;
        end else if (s_sync != 4'b0000) begin
          // A different press must be fully released before it can count.
          cnt_d = 8'd0;
        end else if (cnt_q == CntFim) begin
          estado_d = StOcioso;
          botoes_d = 4'b0000;
          mult_d   = 1'b0;
          soltou_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= StOcioso;
      cnt_q    <= 8'd0;
      cand_q   <= 4'b0000;
      botoes_q <= 4'b0000;
      tem_q    <= 1'b0;
      soltou_q <= 1'b0;
      mult_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      botoes_q <= botoes_d;
      tem_q    <= tem_d;
      soltou_q <= soltou_d;
      mult_q   <= mult_d;
    end
  end

  assign botoes     = botoes_q;
  assign tem_jogada = tem_q;
  assign soltou     = soltou_q;
  assign multipla   = mult_q;
  assign db_estado  = estado_q;

endmodule

// File: tb/tb_playseq_entrada_botoes.sv
// Scoreboard bench for playseq_entrada_botoes with DEBOUNCE_CYCLES=4: stimulus queues expected
// pulses, a negedge monitor pops and checks them.
module tb_playseq_entrada_botoes;

  localparam int unsigned D = 4;

  logic       clock;
  logic       reset;
  logic [3:0] botoes_brutos;
  logic [3:0] botoes;
  logic       tem_jogada;
  logic       soltou;
  logic       multipla;
  logic [1:0] db_estado;

  typedef struct {
    logic        kind;   // 0: tem_jogada, 1: soltou
    logic [3:0]  b;
    logic        m;
    int unsigned cyc;
  } evento_t;

  evento_t     sb[$];
  int unsigned cyc;
  int          compared;
  int          mismatched;

  playseq_entrada_botoes #(
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .botoes_brutos (botoes_brutos),
    .botoes        (botoes),
    .tem_jogada    (tem_jogada),
    .soltou        (soltou),
    .multipla      (multipla),
    .db_estado     (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, act, exp, $time);
    end
  endtask

  // Event latency: raw driven at a negedge with cyc=c gives a pulse seen at negedge with cyc=c+D+3.
  task automatic esperar(input logic kind, input logic [3:0] b, input logic m, input int unsigned c);
    evento_t e;
    e.kind = kind;
    e.b    = b;
    e.m    = m;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic zeros_agora(input string nome);
    chk({nome, "_botoes"}, 32'(botoes), 32'h0);
    chk({nome, "_tem_jogada"}, 32'(tem_jogada), 32'h0);
    chk({nome, "_soltou"}, 32'(soltou), 32'h0);
    chk({nome, "_multipla"}, 32'(multipla), 32'h0);
    chk({nome, "_estado"}, 32'(db_estado), 32'h0);
  endtask

  always @(negedge clock) begin
    if (tem_jogada || soltou) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL pulso_inesperado: got tem_jogada=%0b soltou=%0b expected none (cyc=%0d)",
                 tem_jogada, soltou, cyc);
      end else begin
        evento_t e;
        e = sb.pop_front();
        chk("pulso_tipo", 32'({tem_jogada, soltou}), e.kind ? 32'h1 : 32'h2);
        chk("pulso_botoes", 32'(botoes), 32'(e.b));
        chk("pulso_multipla", 32'(multipla), 32'(e.m));
        chk("pulso_ciclo", cyc, e.cyc);
      end
    end
  end

  initial begin
    int unsigned c;
    logic        viu11;
    int          ruins;

    compared      = 0;
    mismatched    = 0;
    reset         = 1'b0;
    botoes_brutos = 4'b0000;
    #1;
    zeros_agora("reset_inicial");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Single-button press and release.
    c = cyc;
    esperar(1'b0, 4'b0010, 1'b0, c + D + 3);
    botoes_brutos = 4'b0010;
    repeat (10) @(negedge clock);
    chk("press_0010_botoes", 32'(botoes), 32'h2);
    chk("press_0010_estado", 32'(db_estado), 32'h2);
    c = cyc;
    esperar(1'b1, 4'b0000, 1'b0, c + D + 3);
    botoes_brutos = 4'b0000;
    repeat (10) @(negedge clock);
    chk("solta_0010_estado", 32'(db_estado), 32'h0);
    chk("solta_0010_botoes", 32'(botoes), 32'h0);

    // Bouncing input never settles long enough.
    for (int i = 0; i < 16; i++) begin
      botoes_brutos = ((i / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
      @(negedge clock);
      chk("quique_estado_bit1", 32'(db_estado[1]), 32'h0);
    end
    botoes_brutos = 4'b0000;
    repeat (6) @(negedge clock);

    // Two buttons at once: flagged, no move.
    botoes_brutos = 4'b0011;
    repeat (10) @(negedge clock);
    chk("multi_multipla", 32'(multipla), 32'h1);
    chk("multi_botoes", 32'(botoes), 32'h0);
    chk("multi_estado", 32'(db_estado), 32'h2);
    c = cyc;
    esperar(1'b1, 4'b0000, 1'b0, c + D + 3);
    botoes_brutos = 4'b0000;
    repeat (10) @(negedge clock);
    chk("multi_solta_multipla", 32'(multipla), 32'h0);

    // Short release glitch while held.
    c = cyc;
    esperar(1'b0, 4'b1000, 1'b0, c + D + 3);
    botoes_brutos = 4'b1000;
    repeat (10) @(negedge clock);
    viu11 = 1'b0;
    ruins = 0;
    botoes_brutos = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) botoes_brutos = 4'b1000;
      @(negedge clock);
      if (db_estado == 2'b11) viu11 = 1'b1;
      if (botoes != 4'b1000) ruins++;
    end
    chk("glitch_viu_filtra_solta", 32'(viu11), 32'h1);
    chk("glitch_botoes_estavel", ruins, 0);
    chk("glitch_estado_final", 32'(db_estado), 32'h2);
    c = cyc;
    esperar(1'b1, 4'b0000, 1'b0, c + D + 3);
    botoes_brutos = 4'b0000;
    repeat (10) @(negedge clock);

    // Direct change to another button requires a full release first.
    c = cyc;
    esperar(1'b0, 4'b0001, 1'b0, c + D + 3);
    botoes_brutos = 4'b0001;
    repeat (10) @(negedge clock);
    botoes_brutos = 4'b0010;
    repeat (10) @(negedge clock);
    chk("troca_estado", 32'(db_estado), 32'h3);
    chk("troca_botoes", 32'(botoes), 32'h1);
    // Already in FILTRA_SOLTA: four zero samples suffice, one cycle sooner than the usual latency.
    c = cyc;
    esperar(1'b1, 4'b0000, 1'b0, c + D + 2);
    botoes_brutos = 4'b0000;
    repeat (10) @(negedge clock);
    chk("troca_solta_estado", 32'(db_estado), 32'h0);

    // Reset during FILTRA_ATIVO, then the held button is filtered again.
    botoes_brutos = 4'b0100;
    repeat (3) @(negedge clock);
    chk("pre_reset_estado", 32'(db_estado), 32'h1);
    #2 reset = 1'b0;
    #1 zeros_agora("reset_filtra");
    @(negedge clock);
    reset = 1'b1;
    c = cyc;
    esperar(1'b0, 4'b0100, 1'b0, c + D + 3);
    repeat (10) @(negedge clock);
    chk("refiltra_botoes", 32'(botoes), 32'h4);

    // Reset during PRESSIONADO aborts without a release pulse.
    #2 reset = 1'b0;
    #1 zeros_agora("reset_press");
    botoes_brutos = 4'b0000;
    @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    chk("pos_reset_estado", 32'(db_estado), 32'h0);

    chk("scoreboard_vazio", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/playseq_entrada_botoes.md
PLAYSEQ_ENTRADA_BOTOES -- requirements
Module: playseq_entrada_botoes

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20, meaning the number of consecutive stable clock cycles required to accept a press or release (legal range 2..255).
REQ-002 SHALL have port clock, input, 1 bit: the single system clock (1 kHz game clock); all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port botoes_brutos, input, 4 bits: raw asynchronous push-button levels, active-high.
REQ-005 SHALL have port botoes, output, 4 bits: debounced one-hot button code, or 0000; this feeds the datapath botoes input.
REQ-006 SHALL have port tem_jogada, output, 1 bit: single-cycle pulse when a valid one-hot press is accepted.
REQ-007 SHALL have port soltou, output, 1 bit: single-cycle pulse when a full release is accepted.
REQ-008 SHALL have port multipla, output, 1 bit: level, high while an accepted press has more than one button.
REQ-009 SHALL have port db_estado, output, 2 bits: current FSM state code.

Function
REQ-010 SHALL pass botoes_brutos through a two-flop synchronizer; the FSM sees only the synchronized value s_sync.
REQ-011 SHALL implement the FSM OCIOSO=00, FILTRA_ATIVO=01, PRESSIONADO=10, FILTRA_SOLTA=11.
REQ-012 OCIOSO: if s_sync is not 0000, SHALL capture candidato=s_sync, clear cnt and go to FILTRA_ATIVO.
REQ-013 FILTRA_ATIVO, s_sync==0000: SHALL return to OCIOSO with no pulse.
REQ-014 FILTRA_ATIVO, s_sync nonzero but not candidato: SHALL recapture candidato, clear cnt and stay.
REQ-015 FILTRA_ATIVO, s_sync==candidato: SHALL increment cnt; when cnt==DEBOUNCE_CYCLES-1, SHALL go to PRESSIONADO.
REQ-016 On entering PRESSIONADO with one-hot candidato: SHALL set botoes=candidato and pulse tem_jogada for 1 cycle.
REQ-017 On entering PRESSIONADO with multi-bit candidato: SHALL keep botoes=0000, set multipla=1 and not pulse tem_jogada.
REQ-018 PRESSIONADO: if s_sync differs from candidato, SHALL clear cnt and go to FILTRA_SOLTA; botoes and multipla stay unchanged.
REQ-019 FILTRA_SOLTA: if s_sync==candidato, SHALL return to PRESSIONADO with no pulse (release glitch).
REQ-020 FILTRA_SOLTA: if s_sync is nonzero and not candidato, SHALL clear cnt and stay; there is no press-to-press transition without full release.
REQ-021 FILTRA_SOLTA: while s_sync==0000, SHALL increment cnt; when cnt==DEBOUNCE_CYCLES-1, SHALL go to OCIOSO, clear botoes and multipla, and pulse soltou for 1 cycle.
REQ-022 Latency: with edge 0 as the first edge that samples a new stable raw value, tem_jogada and soltou SHALL be high in the cycle following edge DEBOUNCE_CYCLES+2.
REQ-023 tem_jogada and soltou SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per accepted event.
REQ-024 cnt SHALL be 8 bits and SHALL saturate; it SHALL never wrap.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 reset low SHALL immediately set: synchronizer flops 0, state OCIOSO, cnt 0, candidato 0000, botoes 0000, tem_jogada 0, soltou 0, multipla 0, db_estado 00.
REQ-027 Reset asserted mid-press SHALL abort without any pulse; after deassertion a still-held button SHALL be re-filtered from OCIOSO.

Structure
REQ-028 SHALL take state codes and the DEBOUNCE_CYCLES default from the shared package playseq_pkg.
REQ-029 SHALL instantiate one sub-module, sincronizador_2ff (4-bit wide, same clock and reset).

Verification
REQ-030 DEBOUNCE_CYCLES=4, raw 0010 held 10 cycles: botoes=0010 and one tem_jogada pulse after edge 6.
REQ-031 Raw 0100 toggling every 2 cycles: no tem_jogada; state alternates only between 00 and 01.
REQ-032 Raw 0011 held: multipla=1, botoes=0000, no tem_jogada; then release: soltou pulses and multipla clears.
REQ-033 Pressed 1000, then a 2-cycle 0000 glitch: state goes 10->11->10, botoes stays 1000, no soltou.
REQ-034 Press 0001 accepted, then raw changes directly to 0010: no new tem_jogada until 0000 has been held 4 cycles, then soltou pulses.
REQ-035 reset pulsed low during FILTRA_ATIVO and during PRESSIONADO: all outputs are 0 immediately, and no pulse is emitted.
